// File: rtl/cska_sub16_seq_pkg.sv
// Shared types and constants for the sequential 16-bit carry-skip subtractor.
// Holds the FSM encoding, datapath widths and the saturation limits.
package cska_sub16_seq_pkg;

    localparam int DATA_W  = 16;
    localparam int GROUP_W = 4;
    localparam int NGROUPS = DATA_W / GROUP_W;

    localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed overflow of a - b: operands differ in sign and the result sign left a's.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/cska_sub16_seq_group4.sv
// One 4-bit carry-skip group: ripple adder whose carry-out is bypassed by
// the carry-in when every bit position propagates.
module cska_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            s[i]   = p[i] ^ c[i];
        end
    end

    assign co = (&p) ? ci : c[4];

endmodule

// File: rtl/cska_sub16_seq.sv
// Sequential 16-bit subtractor: Diff = A - B - Bin, one 4-bit carry-skip group
// reused over four cycles, LSB nibble first. Optional macro SUB_SAT_EN clamps Diff on overflow.
module cska_sub16_seq
    import cska_sub16_seq_pkg::*;
#(
    parameter int GROUP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Diff,
    output logic              Bout,
    output logic              Ovf
);

    localparam int        K_W    = $clog2(DATA_W / GROUP_W);
    localparam logic [K_W-1:0] K_LAST = K_W'(DATA_W / GROUP_W - 1);

    state_e              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   bn_q, bn_d;
    logic                c_q, c_d;
    logic [DATA_W-1:0]   diff_q, diff_d;
    logic                bout_q, bout_d;
    logic                ovf_q, ovf_d;

    logic [GROUP_W-1:0]  grp_a;
    logic [GROUP_W-1:0]  grp_b;
    logic [GROUP_W-1:0]  grp_s;
    logic                grp_co;

`ifdef SUB_SAT_EN
    function automatic logic [DATA_W-1:0] saturate(input logic [DATA_W-1:0] d,
                                                    input logic ovf,
                                                    input logic a_msb);
        if (ovf) return a_msb ? SAT_MIN : SAT_MAX;
        return d;
    endfunction
`endif

    assign grp_a = a_q[int'(k_q) * GROUP_W +: GROUP_W];
    assign grp_b = bn_q[int'(k_q) * GROUP_W +: GROUP_W];

    cska_group4 u_group (
        .a  (grp_a),
        .b  (grp_b),
        .ci (c_q),
        .s  (grp_s),
        .co (grp_co)
    );

    // Subtraction is A + ~B + ~Bin, so the inverted subtrahend and borrow are latched.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        bn_d    = bn_q;
        c_d     = c_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    bn_d    = ~B;
                    c_d     = ~Bin;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                diff_d[int'(k_q) * GROUP_W +: GROUP_W] = grp_s;
                c_d = grp_co;
                k_d = k_q + K_W'(1);
                if (k_q == K_LAST) begin
                    bout_d  = ~grp_co;
                    ovf_d   = signed_ovf(a_q[DATA_W-1], ~bn_q[DATA_W-1], grp_s[GROUP_W-1]);
`ifdef SUB_SAT_EN
                    diff_d  = saturate(diff_d, ovf_d, a_q[DATA_W-1]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            bn_q    <= '0;
            c_q     <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            bn_q    <= bn_d;
            c_q     <= c_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Diff      = diff_q;
    assign Bout      = bout_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_cska_sub16_seq.sv
// Scoreboard bench for cska_sub16_seq: directed corner cases, back-pressure,
// mid-operation reset and a short random stream.
module tb_cska_sub16_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Diff;
    logic        Bout;
    logic        Ovf;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    cska_sub16_seq #(.GROUP_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Ovf       (Ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        exp_t        e;
        logic [16:0] full;
        full   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        e.diff = full[15:0];
        e.bout = full[16];
        e.ovf  = (a[15] != b[15]) && (full[15] != a[15]);
`ifdef SUB_SAT_EN
        if (e.ovf) e.diff = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return e;
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin, input int hold);
        exp_t        e;
        int          cnt;
        logic [15:0] d0;
        sb.push_back(model(a, b, bin));
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(posedge clk); #1; cnt++;
        end
        chk("in_ready_idle", in_ready, 1);
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready_busy", in_ready, 0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1; cnt++;
        end
        chk("latency", cnt, 4);
        // offer a different operand pair while the result waits; it must not be taken
        A = ~a; B = ~b; in_valid = 1'b1;
        d0 = Diff;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_diff", Diff, d0);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("diff", Diff, e.diff);
            chk("bout", Bout, e.bout);
            chk("ovf", Ovf, e.ovf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        int   seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Bin = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", Diff, 0);
        chk("rst_bout", Bout, 0);
        chk("rst_ovf", Ovf, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // out_ready while idle is ignored
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);

        run_op(16'd5,      16'd3,      1'b0, 0);
        run_op(16'd0,      16'd1,      1'b0, 1);
        run_op(16'h8000,   16'd1,      1'b0, 0);
        run_op(16'h7FFF,   16'hFFFF,   1'b0, 0);
        run_op(16'h00F0,   16'h00F0,   1'b1, 0);
        run_op(16'h1234,   16'h1234,   1'b0, 2);
        run_op(16'h0000,   16'h0000,   1'b1, 0);
        run_op(16'hABCD,   16'h5432,   1'b0, 3);

        // mid-CALC reset discards the operation
        A = 16'd9; B = 16'd2; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_diff", Diff, 0);
        chk("mid_rst_bout", Bout, 0);
        chk("mid_rst_ovf", Ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("no_ovalid_after_rst", seen, 0);

        for (int i = 0; i < 16; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
